// File: rtl/banked_buffer_wrapper_pkg.sv
// Shared types and constants for the banked EPU/host buffer.
package epu_buf_pkg;

  localparam int LEN_W = 8;

  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EPU_RW  = 2'd1,
    RD_XFER = 2'd2,
    WR_XFER = 2'd3
  } state_e;

endpackage

// File: rtl/banked_buffer_wrapper_if.sv
// Host burst bus: read address/data channels, write address/data channels, write-done pulse.
interface banked_buffer_wrapper_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 17
);
  import epu_buf_pkg::*;

  localparam int SW = DATA_W / 8;

  logic              ar_valid_i;
  logic              ar_ready_o;
  logic [AW-1:0]     ar_addr_i;
  logic [LEN_W-1:0]  ar_len_i;
  logic              r_valid_o;
  logic              r_ready_i;
  logic [DATA_W-1:0] r_data_o;
  logic              r_last_o;
  logic              aw_valid_i;
  logic              aw_ready_o;
  logic [AW-1:0]     aw_addr_i;
  logic [LEN_W-1:0]  aw_len_i;
  logic              w_valid_i;
  logic              w_ready_o;
  logic [DATA_W-1:0] w_data_i;
  logic [SW-1:0]     w_strb_i;
  logic              wr_done_o;

  modport master (
    output ar_valid_i, ar_addr_i, ar_len_i, r_ready_i,
    output aw_valid_i, aw_addr_i, aw_len_i, w_valid_i, w_data_i, w_strb_i,
    input  ar_ready_o, r_valid_o, r_data_o, r_last_o, aw_ready_o, w_ready_o, wr_done_o
  );

  modport slave (
    input  ar_valid_i, ar_addr_i, ar_len_i, r_ready_i,
    input  aw_valid_i, aw_addr_i, aw_len_i, w_valid_i, w_data_i, w_strb_i,
    output ar_ready_o, r_valid_o, r_data_o, r_last_o, aw_ready_o, w_ready_o, wr_done_o
  );

endinterface

// File: rtl/banked_buffer_wrapper_bank.sv
// Single-port byte-writable SRAM bank with a registered (1-cycle) read port.
module buffer_bank
  import epu_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 1024,
  localparam int RW = $clog2(WORDS),
  localparam int SW = DATA_W / 8
) (
  input  logic              clk,
  input  logic              cs,
  input  logic [SW-1:0]     we,
  input  logic [RW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Write the enabled bytes, or read the word when no byte is enabled; rdata holds otherwise.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we == {SW{WRITE_DIS}}) rdata <= mem[addr];
      for (int i = 0; i < SW; i++) begin
        if (we[i] == WRITE_ENB) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/banked_buffer_wrapper.sv
// Word-interleaved banked buffer shared between an EPU (direct access) and a host burst bus.
module banked_buffer_wrapper
  import epu_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 98304,
  parameter int NBANK  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb_i,
  input  logic                  start_i,
  input  logic                  finish_i,
  banked_buffer_wrapper_if.slave bus,
  input  logic                  epu_cs_i,
  input  logic                  epu_oe_i,
  input  logic [AW-1:0]         epu_addr_i,
  input  logic [SW-1:0]         epu_wen_i,
  input  logic [DATA_W-1:0]     epu_wdata_i,
  output logic [DATA_W-1:0]     epu_rdata_o
);

  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int RW = $clog2(DEPTH / NBANK);

  state_e            state;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    issue_cnt, load_cnt;
  logic [LEN_W-1:0]  wr_cnt;
  logic              pend;
  logic [BW-1:0]     pend_bank, epu_bank_q;
  logic              out_valid, out_last, wr_done;
  logic [DATA_W-1:0] out_data;

  logic              bank_en;
  logic [AW-1:0]     bank_addr;
  logic [SW-1:0]     bank_we;
  logic [DATA_W-1:0] bank_wdata;
  logic [BW-1:0]     bank_sel;
  logic [RW-1:0]     bank_row;
  logic [DATA_W-1:0] bank_rdata [NBANK];

  logic ar_hs, aw_hs, w_hs, r_hs, load, issue;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign bus.ar_ready_o = (state == IDLE) && !start_i;
  assign bus.aw_ready_o = (state == IDLE) && !start_i && !bus.ar_valid_i;
  assign bus.w_ready_o  = (state == WR_XFER) && enb_i;
  assign bus.r_valid_o  = out_valid;
  assign bus.r_last_o   = out_last;
  assign bus.r_data_o   = out_data;
  assign bus.wr_done_o  = wr_done;

  assign ar_hs = bus.ar_valid_i && bus.ar_ready_o;
  assign aw_hs = bus.aw_valid_i && bus.aw_ready_o;
  assign w_hs  = bus.w_valid_i && bus.w_ready_o;
  assign r_hs  = out_valid && bus.r_ready_i;
  assign load  = pend && (!out_valid || bus.r_ready_i);
  assign issue = (state == RD_XFER) && enb_i && (issue_cnt <= {1'b0, len_q}) && (!pend || load);

  assign bank_sel = BW'(bank_addr % AW'(NBANK));
  assign bank_row = RW'(bank_addr / AW'(NBANK));

  assign epu_rdata_o = ((state == EPU_RW) && epu_oe_i) ? bank_rdata[epu_bank_q] : '0;

  // Steer the single shared bank request from whichever side owns the buffer this cycle.
  always_comb begin
    bank_en    = 1'b0;
    bank_addr  = epu_addr_i;
    bank_we    = {SW{WRITE_DIS}};
    bank_wdata = epu_wdata_i;
    case (state)
      EPU_RW: begin
        bank_en = epu_cs_i;
        bank_we = epu_wen_i;
      end
      RD_XFER: begin
        bank_en   = issue;
        bank_addr = rd_addr;
      end
      WR_XFER: begin
        bank_en    = w_hs;
        bank_addr  = wr_addr;
        bank_we    = bus.w_strb_i;
        bank_wdata = bus.w_data_i;
      end
      default: ;
    endcase
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    buffer_bank #(
      .DATA_W (DATA_W),
      .WORDS  (DEPTH / NBANK)
    ) u_bank (
      .clk   (clk),
      .cs    (bank_en && (bank_sel == BW'(b))),
      .we    (bank_we),
      .addr  (bank_row),
      .wdata (bank_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // Ownership FSM plus the read prefetch pipeline and write burst tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      wr_addr    <= '0;
      len_q      <= '0;
      issue_cnt  <= '0;
      load_cnt   <= '0;
      wr_cnt     <= '0;
      pend       <= 1'b0;
      pend_bank  <= '0;
      epu_bank_q <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      wr_done    <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= EPU_RW;
          end else if (ar_hs) begin
            state     <= RD_XFER;
            rd_addr   <= bus.ar_addr_i;
            len_q     <= bus.ar_len_i;
            issue_cnt <= '0;
            load_cnt  <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (aw_hs) begin
            state   <= WR_XFER;
            wr_addr <= bus.aw_addr_i;
            len_q   <= bus.aw_len_i;
            wr_cnt  <= '0;
          end
        end
        EPU_RW: begin
          if (epu_cs_i) epu_bank_q <= bank_sel;
          if (finish_i) state <= IDLE;
        end
        RD_XFER: begin
          if (!enb_i) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pend      <= 1'b0;
          end else begin
            pend <= issue || (pend && !load);
            if (issue) begin
              rd_addr   <= next_addr(rd_addr);
              issue_cnt <= issue_cnt + 1'b1;
              pend_bank <= bank_sel;
            end
            if (load) begin
              out_valid <= 1'b1;
              out_data  <= bank_rdata[pend_bank];
              out_last  <= (load_cnt == {1'b0, len_q});
              load_cnt  <= load_cnt + 1'b1;
            end else if (r_hs) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
            if (r_hs && out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              pend      <= 1'b0;
            end
          end
        end
        WR_XFER: begin
          if (!enb_i) begin
            state <= IDLE;
          end else if (w_hs) begin
            wr_addr <= next_addr(wr_addr);
            wr_cnt  <= wr_cnt + 1'b1;
            if (wr_cnt == len_q) begin
              state   <= IDLE;
              wr_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/banked_buffer_wrapper.md
BANKED_BUFFER_WRAPPER -- requirements
Module: banked_buffer_wrapper

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 98304, total words (multiple of NBANK).
REQ-003 SHALL have parameter NBANK, default 4, power-of-two bank count, word-interleaved.
REQ-004 SHALL have ports, clock and reset first; AW = clog2(DEPTH), SW = DATA_W/8:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- enb_i  in  1  host access enable; low aborts host operation
- start_i  in  1  EPU requests buffer ownership
- finish_i  in  1  EPU releases ownership
- ar_valid_i / ar_ready_o  in/out  1  host read request handshake
- ar_addr_i  in  AW  read start word address
- ar_len_i  in  8  read beats minus one
- r_valid_o / r_ready_i  out/in  1  read data handshake
- r_data_o  out  DATA_W  read data
- r_last_o  out  1  final read beat
- aw_valid_i / aw_ready_o  in/out  1  host write request handshake
- aw_addr_i  in  AW  write start word address
- aw_len_i  in  8  write beats minus one
- w_valid_i / w_ready_o  in/out  1  write data handshake
- w_data_i  in  DATA_W  write data
- w_strb_i  in  SW  byte enables
- wr_done_o  out  1  one-cycle pulse after last write beat
- epu_cs_i, epu_oe_i  in  1  EPU chip select, output enable
- epu_addr_i  in  AW  EPU word address
- epu_wen_i  in  SW  EPU byte write enables
- epu_wdata_i  in  DATA_W  EPU write data
- epu_rdata_o  out  DATA_W  EPU read data, 1-cycle latency

Function
REQ-005 SHALL implement states IDLE, EPU_RW, RD_XFER, WR_XFER.
REQ-006 IDLE: start_i -> EPU_RW; else ar_valid_i -> RD_XFER; else aw_valid_i -> WR_XFER; start_i wins simultaneous requests, read wins over write.
REQ-007 ar_ready_o/aw_ready_o SHALL be high only in IDLE with start_i low, read taking priority; address and length latched on handshake.
REQ-008 EPU_RW SHALL pass EPU signals straight to the bank addr mod NBANK, row addr/NBANK; exits to IDLE on finish_i; host ready signals stay low.
REQ-009 epu_rdata_o SHALL be 0 outside EPU_RW.
REQ-010 RD_XFER: first r_valid_o exactly 2 cycles after ar handshake; bank read latency 1 cycle into a one-word output register.
REQ-011 Next read SHALL issue when output register empty or consumed that cycle, sustaining one beat per cycle with r_ready_i high.
REQ-012 r_valid_o/r_data_o SHALL hold stable while r_ready_i low; no beat dropped or duplicated.
REQ-013 r_last_o SHALL be high with beat ar_len_i+1; its handshake returns to IDLE.
REQ-014 WR_XFER: w_ready_o high; each w handshake writes bytes enabled by w_strb_i at current address, then increments.
REQ-015 Final write beat SHALL return to IDLE and pulse wr_done_o next cycle.
REQ-016 Burst addresses SHALL wrap from DEPTH-1 to 0.
REQ-017 enb_i low in RD_XFER/WR_XFER SHALL abort to IDLE next cycle, clearing r_valid_o, no further writes, no wr_done_o.
REQ-018 All bank chip selects SHALL be low in IDLE.

Reset
REQ-019 On rst: state IDLE; r_valid_o, r_last_o, wr_done_o, w_ready_o 0; r_data_o, epu_rdata_o 0; counters 0; ar_ready_o/aw_ready_o follow REQ-007.
REQ-020 Reset mid-burst SHALL discard the burst; SRAM contents are not cleared.

Structure
REQ-021 State enum, WRITE_ENB/WRITE_DIS constants and length width SHALL live in shared package epu_buf_pkg.
REQ-022 SHALL instantiate NBANK copies of sub-module buffer_bank (single-port, byte-write, 1-cycle read, DEPTH/NBANK words) via generate.

Verification
REQ-023 Write 4 beats 0x11111111..0x44444444 at addr 6, strobe 0xF; read 4 at 6 -> same data, r_last_o on beat 4, wr_done_o one pulse.
REQ-024 Read len 7 at 8 with r_ready_i toggling every cycle -> 8 beats in order, data stable while stalled.
REQ-025 Write strobe 0x3 data 0xAABBCCDD over 0x12345678 -> read 0x1234CCDD.
REQ-026 Burst at DEPTH-2, len 3 -> accesses DEPTH-2, DEPTH-1, 0, 1.
REQ-027 start_i and ar_valid_i same cycle -> EPU_RW, ar_ready_o 0; EPU write 0xCAFEF00D addr 5, finish_i, host read addr 5 -> 0xCAFEF00D.
REQ-028 enb_i low mid-read, then rst mid-write -> IDLE, r_valid_o 0, no wr_done_o, later writes unaffected.
